// File: rtl/shift_pkg.sv
// Shared definitions for the shift_pipe barrel shifter:
// op encodings and shift-amount width helpers.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_ROTL = 3'b000,
    OP_SRL  = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROTR = 3'b100
  } op_e;

  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return !op[2] || (op[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice: shift levels LO..HI-1 applied
// combinationally, then captured with the sideband bits.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO    = 0,
  parameter int HI    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      up_valid,
  input  logic [WIDTH-1:0]          up_data,
  input  logic [shamt_w(WIDTH)-1:0] up_shamt,
  input  logic [2:0]                up_op,
  input  logic                      up_fill,
  input  logic                      up_illegal,
  output logic                      valid,
  output logic [WIDTH-1:0]          data,
  output logic [shamt_w(WIDTH)-1:0] shamt,
  output logic [2:0]                op,
  output logic                      fill,
  output logic                      illegal,
  output logic                      zero
);

  localparam int SW = shamt_w(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] res;
  logic [SW-1:0]    bits;

  // Level k moves the data by 2**k, always less than WIDTH
  always_comb begin
    res  = up_data;
    bits = '0;
    for (int k = LO; k < HI; k++) begin
      bits = up_shamt >> k;
      if (bits[0]) begin
        case (up_op)
          OP_ROTL: res = (res << (1 << k))
                       | (res >> (WIDTH - (1 << k)));
          OP_ROTR: res = (res >> (1 << k))
                       | (res << (WIDTH - (1 << k)));
          OP_SLL:  res = res << (1 << k);
          OP_SRL:  res = res >> (1 << k);
          OP_SRA:  res = (res >> (1 << k))
                       | ({WIDTH{up_fill}}
                          & ~(ONES >> (1 << k)));
          default: res = res;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      data    <= '0;
      shamt   <= '0;
      op      <= '0;
      fill    <= 1'b0;
      illegal <= 1'b0;
      zero    <= 1'b0;
    end else if (en) begin
      valid <= up_valid;
      if (up_valid) begin
        data    <= res;
        shamt   <= up_shamt;
        op      <= up_op;
        fill    <= up_fill;
        illegal <= up_illegal;
        zero    <= (res == '0);
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Elastic multi-stage barrel shifter / rotator with
// valid/ready handshakes on both sides.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [shamt_w(WIDTH)-1:0] in_shamt,
  input  logic [2:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_zero,
  output logic                      out_illegal
);

  localparam int SW = shamt_w(WIDTH);

  logic [STAGES:0]   vl;
  logic [STAGES:0]   fl;
  logic [STAGES:0]   il;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] zv;
  logic [WIDTH-1:0]  d  [STAGES+1];
  logic [SW-1:0]     sh [STAGES+1];
  logic [2:0]        op [STAGES+1];
  logic              legal;
  logic              unused;

  // Reserved ops enter as zero data and pass untouched
  assign legal = op_legal(in_op);
  assign vl[0] = in_valid;
  assign d[0]  = legal ? in_data : '0;
  assign sh[0] = in_shamt;
  assign op[0] = in_op;
  assign fl[0] = in_data[WIDTH-1];
  assign il[0] = !legal;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // Loadable unless every stage from here down is full and stalled
    assign en[s] = out_ready | ~(&vl[STAGES:s+1]);

    shift_stage #(
      .WIDTH (WIDTH),
      .LO    (s * SW / STAGES),
      .HI    ((s + 1) * SW / STAGES)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[s]),
      .up_valid   (vl[s]),
      .up_data    (d[s]),
      .up_shamt   (sh[s]),
      .up_op      (op[s]),
      .up_fill    (fl[s]),
      .up_illegal (il[s]),
      .valid      (vl[s+1]),
      .data       (d[s+1]),
      .shamt      (sh[s+1]),
      .op         (op[s+1]),
      .fill       (fl[s+1]),
      .illegal    (il[s+1]),
      .zero       (zv[s])
    );
  end

  assign in_ready    = en[0];
  assign out_valid   = vl[STAGES];
  assign out_data    = d[STAGES];
  assign out_illegal = il[STAGES];
  assign out_zero    = zv[STAGES-1];

  assign unused = ^{sh[STAGES], op[STAGES], fl[STAGES], zv};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: 32-bit/2-stage main instance
// plus an 8-bit/3-stage instance.
module tb_shift_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [2:0]  op;
    logic [31:0] exp;
    logic        z;
    logic        il;
  } vec32_t;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] sh;
    logic [2:0] op;
    logic [7:0] exp;
    logic       z;
    logic       il;
  } vec8_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_in_data = '0;
  logic [4:0]  a_in_shamt = '0;
  logic [2:0]  a_in_op = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [31:0] a_out_data;
  logic        a_out_zero;
  logic        a_out_illegal;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in_data = '0;
  logic [2:0] b_in_shamt = '0;
  logic [2:0] b_in_op = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [7:0] b_out_data;
  logic       b_out_zero;
  logic       b_out_illegal;

  int errors = 0;
  int checks = 0;

  vec32_t tab [16];
  vec8_t  tb8 [9];

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .STAGES(2)) u_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in_data     (a_in_data),
    .in_shamt    (a_in_shamt),
    .in_op       (a_in_op),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .out_data    (a_out_data),
    .out_zero    (a_out_zero),
    .out_illegal (a_out_illegal)
  );

  shift_pipe #(.WIDTH(8), .STAGES(3)) u_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_data     (b_in_data),
    .in_shamt    (b_in_shamt),
    .in_op       (b_in_op),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_data    (b_out_data),
    .out_zero    (b_out_zero),
    .out_illegal (b_out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec32_t v);
    a_in_data  = v.d;
    a_in_shamt = v.sh;
    a_in_op    = v.op;
  endtask

  task automatic run32(input int i);
    @(negedge clk);
    drive_a(tab[i]);
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk($sformatf("a%0d early", i), 64'(a_out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("a%0d valid", i), 64'(a_out_valid), 64'd1);
    chk($sformatf("a%0d data", i), 64'(a_out_data), 64'(tab[i].exp));
    chk($sformatf("a%0d zero", i), 64'(a_out_zero), 64'(tab[i].z));
    chk($sformatf("a%0d ill", i), 64'(a_out_illegal), 64'(tab[i].il));
  endtask

  task automatic run8(input int i);
    @(negedge clk);
    b_in_data   = tb8[i].d;
    b_in_shamt  = tb8[i].sh;
    b_in_op     = tb8[i].op;
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk($sformatf("b%0d early1", i), 64'(b_out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("b%0d early2", i), 64'(b_out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("b%0d valid", i), 64'(b_out_valid), 64'd1);
    chk($sformatf("b%0d data", i), 64'(b_out_data), 64'(tb8[i].exp));
    chk($sformatf("b%0d zero", i), 64'(b_out_zero), 64'(tb8[i].z));
    chk($sformatf("b%0d ill", i), 64'(b_out_illegal), 64'(tb8[i].il));
  endtask

  // Per-cycle handshake model: decisions taken at the negedge
  task automatic stream32(input int first, input int n,
                          input int hold);
    int sent = 0;
    int got = 0;
    int c = 0;
    int last_c = -1;
    while (got < n && c < 100) begin
      @(negedge clk);
      a_out_ready = (c >= hold);
      if (sent < n) begin
        drive_a(tab[first+sent]);
        a_in_valid = 1'b1;
      end else begin
        a_in_valid = 1'b0;
      end
      if (hold > 0 && sent < n && c == 3) begin
        a_in_valid = 1'b0;
        a_in_data  = 32'hDEAD_BEEF;
        a_in_op    = 3'b110;
      end
      #1;
      if (hold > 0 && c == 2)
        chk("bp in_ready", 64'(a_in_ready), 64'd0);
      if (a_out_valid && !a_out_ready)
        chk($sformatf("bp held c%0d", c), 64'(a_out_data),
            64'(tab[first+got].exp));
      if (a_out_valid && a_out_ready) begin
        chk($sformatf("st%0d res%0d", first, got),
            64'(a_out_data), 64'(tab[first+got].exp));
        got++;
        last_c = c;
      end
      if (a_in_valid && a_in_ready) sent++;
      c++;
    end
    chk($sformatf("st%0d count", first), 64'(got), 64'(n));
    if (hold == 0)
      chk($sformatf("st%0d cycles", first), 64'(last_c),
          64'(n + 1));
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    chk($sformatf("st%0d drained", first), 64'(a_out_valid),
        64'd0);
  endtask

  initial begin
    int stale;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int stale;
    tab[0]  = '{32'h80000001, 5'd1,  3'b000, 32'h00000003, 1'b0, 1'b0};
    tab[1]  = '{32'h80000000, 5'd31, 3'b011, 32'hFFFFFFFF, 1'b0, 1'b0};
    tab[2]  = '{32'h80000000, 5'd31, 3'b001, 32'h00000001, 1'b0, 1'b0};
    tab[3]  = '{32'h12345678, 5'd0,  3'b100, 32'h12345678, 1'b0, 1'b0};
    tab[4]  = '{32'h12345678, 5'd4,  3'b100, 32'h81234567, 1'b0, 1'b0};
    tab[5]  = '{32'hFFFFFFFF, 5'd5,  3'b110, 32'h00000000, 1'b1, 1'b1};
    tab[6]  = '{32'h12345678, 5'd0,  3'b000, 32'h12345678, 1'b0, 1'b0};
    tab[7]  = '{32'h00000001, 5'd31, 3'b010, 32'h80000000, 1'b0, 1'b0};
    tab[8]  = '{32'h80000001, 5'd1,  3'b010, 32'h00000002, 1'b0, 1'b0};
    tab[9]  = '{32'h7FFFFFFF, 5'd4,  3'b011, 32'h07FFFFFF, 1'b0, 1'b0};
    tab[10] = '{32'h80000000, 5'd1,  3'b010, 32'h00000000, 1'b1, 1'b0};
    tab[11] = '{32'h12345678, 5'd8,  3'b000, 32'h34567812, 1'b0, 1'b0};
    tab[12] = '{32'h0000F000, 5'd12, 3'b001, 32'h0000000F, 1'b0, 1'b0};
    tab[13] = '{32'h12345678, 5'd31, 3'b100, 32'h2468ACF0, 1'b0, 1'b0};
    tab[14] = '{32'h00000000, 5'd0,  3'b101, 32'h00000000, 1'b1, 1'b1};
    tab[15] = '{32'h80000000, 5'd0,  3'b011, 32'h80000000, 1'b0, 1'b0};

    tb8[0] = '{8'h81, 3'd1, 3'b000, 8'h03, 1'b0, 1'b0};
    tb8[1] = '{8'h80, 3'd7, 3'b011, 8'hFF, 1'b0, 1'b0};
    tb8[2] = '{8'h80, 3'd7, 3'b001, 8'h01, 1'b0, 1'b0};
    tb8[3] = '{8'h12, 3'd4, 3'b100, 8'h21, 1'b0, 1'b0};
    tb8[4] = '{8'h12, 3'd0, 3'b100, 8'h12, 1'b0, 1'b0};
    tb8[5] = '{8'hFF, 3'd3, 3'b111, 8'h00, 1'b1, 1'b1};
    tb8[6] = '{8'h96, 3'd3, 3'b010, 8'hB0, 1'b0, 1'b0};
    tb8[7] = '{8'h96, 3'd2, 3'b011, 8'hE5, 1'b0, 1'b0};
    tb8[8] = '{8'h5A, 3'd5, 3'b000, 8'h4B, 1'b0, 1'b0};

    #1;
    chk("rst out_valid", 64'(a_out_valid), 64'd0);
    chk("rst out_data", 64'(a_out_data), 64'd0);
    chk("rst out_zero", 64'(a_out_zero), 64'd0);
    chk("rst out_ill", 64'(a_out_illegal), 64'd0);
    chk("rst b out_valid", 64'(b_out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst in_ready", 64'(a_in_ready), 64'd1);
    chk("post rst b in_ready", 64'(b_in_ready), 64'd1);

    for (int i = 0; i < 16; i++) run32(i);
    for (int i = 0; i < 9; i++) run8(i);

    stream32(0, 4, 5);
    stream32(6, 6, 0);

    // Two requests in flight, then reset mid-pipeline
    @(negedge clk);
    a_out_ready = 1'b1;
    drive_a(tab[5]);
    a_in_valid = 1'b1;
    @(negedge clk);
    drive_a(tab[4]);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("pre rst valid", 64'(a_out_valid), 64'd1);
    chk("pre rst ill", 64'(a_out_illegal), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 64'(a_out_valid), 64'd0);
    chk("mid rst data", 64'(a_out_data), 64'd0);
    chk("mid rst zero", 64'(a_out_zero), 64'd0);
    chk("mid rst ill", 64'(a_out_illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_out_valid) stale++;
    end
    chk("no stale result", 64'(stale), 64'd0);
    chk("rst in_ready", 64'(a_in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
